// File: rtl/display_pkg.sv
// Shared types and constants for the eight-digit multiplexed seven-segment scanner.
// Optional leading-zero blanking is enabled with `DISPLAY_LZ_BLANK_EN.
package display_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [2:0] digit_idx_t;
    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // One complete set of display data: what is shown, or what is waiting to be shown.
    typedef struct packed {
        logic [31:0] value;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_data_t;

    localparam disp_data_t ACTIVE_RESET  = '{value: 32'h0000_0000, dp: 8'h00, en: 8'hFF};
    localparam disp_data_t PENDING_RESET = '{value: 32'h0000_0000, dp: 8'h00, en: 8'h00};

    function automatic logic [3:0] nibble_at(input logic [31:0] value, input digit_idx_t idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational hex nibble to active-low seven-segment glyph (bit 0 = a ... bit 6 = g).
module hex_to_sevenseg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    // Glyph lookup; lower-case b and d keep them distinct from 8 and 0.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0:    seg = 7'b100_0000;
            4'h1:    seg = 7'b111_1001;
            4'h2:    seg = 7'b010_0100;
            4'h3:    seg = 7'b011_0000;
            4'h4:    seg = 7'b001_1001;
            4'h5:    seg = 7'b001_0010;
            4'h6:    seg = 7'b000_0010;
            4'h7:    seg = 7'b111_1000;
            4'h8:    seg = 7'b000_0000;
            4'h9:    seg = 7'b001_0000;
            4'hA:    seg = 7'b000_1000;
            4'hB:    seg = 7'b000_0011;
            4'hC:    seg = 7'b100_0110;
            4'hD:    seg = 7'b010_0001;
            4'hE:    seg = 7'b000_0110;
            4'hF:    seg = 7'b000_1110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-synchronous double-buffered updates.
// Define `DISPLAY_LZ_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value_i,
    input  logic [7:0]  dp_i,
    input  logic [7:0]  en_i,
    input  logic        upd_i,
    output logic        upd_busy_o,
    output logic        frame_done_o,
    output logic [7:0]  AN,
    output seg_t        SEG,
    output logic        DP
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    digit_idx_t       digit_r;
    disp_data_t       active_r;
    disp_data_t       pending_r;
    logic             busy_r;

    logic             tick_s;
    logic             frame_done_s;
    logic [3:0]       nibble_s;
    seg_t             glyph_s;
    logic             lz_blank_s;
    logic             digit_on_s;

    assign tick_s = (cnt_r == CNT_LAST);
    // Gated by reset so a reset landing on the last slot cannot emit a frame pulse.
    assign frame_done_s = tick_s && (digit_r == 3'd7) && !reset;

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            digit_r <= 3'd0;
        end else if (tick_s) begin
            cnt_r   <= '0;
            digit_r <= digit_r + 3'd1;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            digit_r <= digit_r;
        end
    end

    // Pending/active double buffer; pending moves to active only on the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r  <= ACTIVE_RESET;
            pending_r <= PENDING_RESET;
            busy_r    <= 1'b0;
        end else begin
            if (frame_done_s && busy_r) begin
                active_r <= pending_r;
            end
            if (upd_i) begin
                pending_r <= '{value: value_i, dp: dp_i, en: en_i};
                busy_r    <= 1'b1;
            end else if (frame_done_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign nibble_s = nibble_at(active_r.value, digit_r);

    hex_to_sevenseg u_glyph (
        .nibble (nibble_s),
        .seg    (glyph_s)
    );

`ifdef DISPLAY_LZ_BLANK_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        logic [NUM_DIGITS-1:0] tail_zero_v;
        logic                  run_v;
        run_v       = 1'b1;
        tail_zero_v = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run_v          = run_v && (active_r.value[4*k +: 4] == 4'h0);
            tail_zero_v[k] = run_v;
        end
        if (digit_r != 3'd0) begin
            lz_blank_s = tail_zero_v[digit_r];
        end else begin
            lz_blank_s = 1'b0;
        end
    end
`else
    assign lz_blank_s = 1'b0;
`endif

    assign digit_on_s = active_r.en[digit_r] && !lz_blank_s;

    // Drive the pins for the current slot; a disabled slot is fully dark.
    always_comb begin
        AN  = AN_OFF;
        SEG = SEG_BLANK;
        DP  = 1'b1;
        if (digit_on_s) begin
            AN  = ~(8'h01 << digit_r);
            SEG = glyph_s;
            DP  = ~active_r.dp[digit_r];
        end else begin
            AN  = AN_OFF;
            SEG = SEG_BLANK;
            DP  = 1'b1;
        end
    end

    assign upd_busy_o   = busy_r;
    assign frame_done_o = frame_done_s;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one parameter: REFRESH_DIV, default 100000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 clk  input  1  single clock for all state; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 value_i  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-005 dp_i  input  8  decimal-point request per digit, active-high.
REQ-006 en_i  input  8  digit enable mask, active-high.
REQ-007 upd_i  input  1  one-cycle strobe that captures value_i, dp_i and en_i.
REQ-008 upd_busy_o  output  1  high while captured data is pending and not yet displayed.
REQ-009 frame_done_o  output  1  one-cycle pulse at the end of each 8-digit frame.
REQ-010 AN  output  8  anode select, active-low, one-hot-zero.
REQ-011 SEG  output  7  cathodes, active-low; SEG[0]=a through SEG[6]=g.
REQ-012 DP  output  1  decimal-point cathode, active-low.

Function
REQ-013 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick SHALL be true in the cycle the count equals REFRESH_DIV-1.
REQ-014 A 3-bit digit index SHALL advance by 1 on tick and wrap from 7 to 0; it SHALL hold otherwise.
REQ-015 frame_done_o SHALL be high for exactly one cycle: the tick cycle in which the digit index is 7.
REQ-016 Active registers (value, dp, en) SHALL change only at a frame boundary (the frame_done_o cycle), so a frame never mixes old and new data.
REQ-017 When upd_i is high, the inputs SHALL be captured into pending registers and upd_busy_o SHALL go high in the next cycle.
REQ-018 In a frame_done_o cycle with pending data, pending SHALL be copied to active and upd_busy_o SHALL clear in the next cycle.
REQ-019 If upd_i is high while busy, pending SHALL be overwritten; the last write wins.
REQ-020 If upd_i coincides with the frame boundary, the old pending data SHALL move to active, the new data SHALL be captured into pending, and upd_busy_o SHALL stay high.
REQ-021 AN, SEG and DP SHALL be combinational functions of the registered digit index and the active registers, with no added latency.
REQ-022 If active en[d] is 1: AN SHALL equal ~(1<<d), SEG SHALL be the hex glyph of nibble d (0-9, A, b, C, d, E, F) and DP SHALL equal ~dp[d].
REQ-023 If active en[d] is 0: AN SHALL be 8'hFF, SEG SHALL be 7'h7F and DP SHALL be 1.

Reset
REQ-024 On reset, the prescaler, digit index, active value, active dp and pending registers SHALL all be 0.
REQ-025 On reset, active en SHALL be 8'hFF, upd_busy_o SHALL be 0 and frame_done_o SHALL be 0.
REQ-026 After reset the outputs SHALL be AN=8'hFE, SEG=7'b1000000 and DP=1.
REQ-027 Reset asserted mid-frame or mid-update SHALL discard pending data, with no frame_done_o pulse.

Configuration
REQ-028 With `DISPLAY_LZ_BLANK_EN defined, digit d>0 SHALL be treated as disabled when all active nibbles from d through 7 are zero; digit 0 is never LZ-blanked.
REQ-029 Without `DISPLAY_LZ_BLANK_EN, the blanking logic SHALL be absent and only en governs blanking.

Structure
REQ-030 Package display_pkg SHALL hold: NUM_DIGITS=8, the digit-index typedef, the 7-bit seg_t typedef, and the SEG_BLANK constant.
REQ-031 The hex-to-glyph decode SHALL be a combinational sub-module, hex_to_sevenseg (4-bit nibble in, seg_t out).

Verification (REFRESH_DIV=4)
REQ-032 Release reset -> AN=FE, SEG=40; AN steps FD, FB, ... 7F every 4 cycles; frame_done_o pulses every 32 cycles.
REQ-033 upd_i with value_i=32'h89ABCDEF mid-frame -> upd_busy_o stays 1 until the frame boundary; the next frame shows F,E,d,C,b,A,9,8 on digits 0..7.
REQ-034 Two upd_i strobes (12345678 then 0000_00A5) in one frame -> only 0000_00A5 appears; with the macro, AN is FF in slots 2..7.
REQ-035 en_i=8'h0F, dp_i=8'h02 -> slots 4..7 give AN=FF, SEG=7F; digit 1 gives DP=0.
REQ-036 upd_i in the frame_done_o cycle -> active takes the prior pending data; upd_busy_o stays 1 one more frame.
REQ-037 Reset asserted at digit 5 with data pending -> next cycle matches REQ-026; upd_busy_o=0.
